// File: rtl/fifo_pkt_formatter.sv
// fifo_pkt_formatter
//   Drains one channel FIFO into fixed-length packets. Once at least PKT_LEN
//   words are buffered (level = MAX_CNT - fifo_slack), the block requests the
//   bus. After the grant it pops PKT_LEN words and streams them out with
//   start/end markers. A packet is counted when its last word has been
//   emitted.
//
// Ports
//   clk, rst        single clock, asynchronous active-high reset
//   fifo_slack      free entries reported by the flag generator
//   fifo_dn_ready   FIFO non-empty
//   fifo_rdata      FIFO read data, valid one cycle after fifo_rd_en
//   fifo_rd_en      pop one FIFO word this cycle
//   fmt_req         bus request (a full packet is buffered)
//   fmt_grant       bus grant (pulse or level)
//   fmt_valid       fmt_data/fmt_start/fmt_end valid this cycle
//   fmt_data        packet word (holds its value while fmt_valid=0)
//   fmt_start       first word of packet
//   fmt_end         last word of packet
//   pkt_cnt         packets completed, 8-bit modulo
module fifo_pkt_formatter #(
  parameter int DATA_W        = 32,
  parameter int FIFO_PTR_WIDE = 3,
  parameter int MAX_CNT       = 8,
  parameter int PKT_LEN       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FIFO_PTR_WIDE:0] fifo_slack,
  input  logic                   fifo_dn_ready,
  input  logic [DATA_W-1:0]      fifo_rdata,
  output logic                   fifo_rd_en,
  output logic                   fmt_req,
  input  logic                   fmt_grant,
  output logic                   fmt_valid,
  output logic [DATA_W-1:0]      fmt_data,
  output logic                   fmt_start,
  output logic                   fmt_end,
  output logic [7:0]             pkt_cnt
);

  localparam int LW = FIFO_PTR_WIDE + 1;
  localparam int CW = $clog2(PKT_LEN + 1);

  localparam logic [LW-1:0] MAX_L  = LW'(MAX_CNT);
  localparam logic [LW-1:0] PKT_L  = LW'(PKT_LEN);
  localparam logic [CW-1:0] PKT_C  = CW'(PKT_LEN);
  localparam logic [CW-1:0] LAST_C = CW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SEND,
    DRAIN
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   rd_cnt, rd_cnt_nxt;
  logic            req_nxt;
  logic            pkt_inc;
  logic [LW-1:0]   level;

  // Stage 1 of the read pipeline: marks that fifo_rdata carries a popped
  // word in this cycle, plus the marker flags computed at pop time.
  logic            p1_valid;
  logic            p1_start;
  logic            p1_end;

  assign level = MAX_L - fifo_slack;

  // fifo_rd_en is a decode of registered state gated by fifo_dn_ready in the
  // same cycle, so a pop can never be issued against an empty FIFO.
  always_comb begin
    state_nxt  = state;
    rd_cnt_nxt = rd_cnt;
    req_nxt    = fmt_req;
    fifo_rd_en = 1'b0;
    pkt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (level >= PKT_L) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
        end
      end
      REQ: begin
        if (fmt_grant) begin
          req_nxt    = 1'b0;
          rd_cnt_nxt = '0;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        if (fifo_dn_ready && (rd_cnt < PKT_C)) begin
          fifo_rd_en = 1'b1;
          rd_cnt_nxt = rd_cnt + CW'(1);
          if (rd_cnt == LAST_C) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Last pop has left stage 1; its word is on the output this cycle.
        if (!p1_valid) begin
          pkt_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      fmt_req   <= 1'b0;
      p1_valid  <= 1'b0;
      p1_start  <= 1'b0;
      p1_end    <= 1'b0;
      fmt_valid <= 1'b0;
      fmt_data  <= '0;
      fmt_start <= 1'b0;
      fmt_end   <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      rd_cnt    <= rd_cnt_nxt;
      fmt_req   <= req_nxt;
      p1_valid  <= fifo_rd_en;
      p1_start  <= fifo_rd_en && (rd_cnt == '0);
      p1_end    <= fifo_rd_en && (rd_cnt == LAST_C);
      fmt_valid <= p1_valid;
      fmt_start <= p1_valid && p1_start;
      fmt_end   <= p1_valid && p1_end;
      if (p1_valid) begin
        fmt_data <= fifo_rdata;
      end
      if (pkt_inc) begin
        pkt_cnt <= pkt_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_formatter.sv
// tb_fifo_pkt_formatter
//   Bench for fifo_pkt_formatter. A behavioural FIFO plus flag generator feeds
//   the PKT_LEN=4 instance; a second PKT_LEN=1 instance reads an always-ready
//   counting source. Expected words are queued as they are written into the
//   FIFO and popped as the DUT emits them.
module tb_fifo_pkt_formatter;

  localparam int DATA_W  = 32;
  localparam int PW      = 3;
  localparam int MAX_CNT = 8;
  localparam int PKT_LEN = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- main DUT and its FIFO model ----------------
  logic              wr;
  logic [DATA_W-1:0] wdata;
  logic              rdy_mask;
  logic              grant;

  logic [PW:0]       fifo_slack;
  logic              fifo_dn_ready;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_rd_en;
  logic              fmt_req;
  logic              fmt_valid;
  logic [DATA_W-1:0] fmt_data;
  logic              fmt_start;
  logic              fmt_end;
  logic [7:0]        pkt_cnt;

  logic [DATA_W-1:0] mem [MAX_CNT];
  logic [2:0]        wptr, rptr;
  logic [3:0]        count;

  assign fifo_slack    = 4'(MAX_CNT) - count;
  assign fifo_dn_ready = (count != 4'd0) && rdy_mask;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      fifo_rdata <= '0;
    end else begin
      if (wr && count < 4'(MAX_CNT)) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 3'd1;
      end
      if (fifo_rd_en && count != 4'd0) begin
        fifo_rdata <= mem[rptr];
        rptr       <= rptr + 3'd1;
      end
      count <= count + 4'(wr && count < 4'(MAX_CNT)) - 4'(fifo_rd_en && count != 4'd0);
    end
  end

  fifo_pkt_formatter #(
    .DATA_W(DATA_W), .FIFO_PTR_WIDE(PW), .MAX_CNT(MAX_CNT), .PKT_LEN(PKT_LEN)
  ) u_dut (
    .clk(clk), .rst(rst),
    .fifo_slack(fifo_slack), .fifo_dn_ready(fifo_dn_ready), .fifo_rdata(fifo_rdata),
    .fifo_rd_en(fifo_rd_en), .fmt_req(fmt_req), .fmt_grant(grant),
    .fmt_valid(fmt_valid), .fmt_data(fmt_data), .fmt_start(fmt_start),
    .fmt_end(fmt_end), .pkt_cnt(pkt_cnt)
  );

  // ---------------- PKT_LEN=1 instance with a counting source ----------------
  logic [PW:0]       slack1;
  logic              rdy1;
  logic              g1_en;
  logic [DATA_W-1:0] src1, rdata1;
  logic              rd1, req1, v1, s1, e1;
  logic [DATA_W-1:0] d1;
  logic [7:0]        pc1;

  assign slack1 = '0;
  assign rdy1   = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      src1   <= '0;
      rdata1 <= '0;
    end else if (rd1) begin
      rdata1 <= src1;
      src1   <= src1 + 1;
    end
  end

  fifo_pkt_formatter #(
    .DATA_W(DATA_W), .FIFO_PTR_WIDE(PW), .MAX_CNT(MAX_CNT), .PKT_LEN(1)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .fifo_slack(slack1), .fifo_dn_ready(rdy1), .fifo_rdata(rdata1),
    .fifo_rd_en(rd1), .fmt_req(req1), .fmt_grant(g1_en),
    .fmt_valid(v1), .fmt_data(d1), .fmt_start(s1),
    .fmt_end(e1), .pkt_cnt(pc1)
  );

  // ---------------- checking infrastructure ----------------
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              s;
    logic              e;
  } exp_t;

  exp_t              sb[$];
  int unsigned       widx;
  logic [DATA_W-1:0] last_data;
  int unsigned       nends;
  logic [DATA_W-1:0] exp1;
  int unsigned       words1;

  typedef struct {
    logic       wr;
    logic       grant;
    logic       rdy;
    logic       req;
    logic       rd;
    logic       v;
    logic       s;
    logic       e;
    logic [7:0] pkt;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(bit w, bit g, bit r, bit q, bit rd, bit v, bit s, bit e,
                              logic [7:0] p);
    vec_t t;
    t.wr = w; t.grant = g; t.rdy = r; t.req = q; t.rd = rd;
    t.v = v; t.s = s; t.e = e; t.pkt = p;
    return t;
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word();
    exp_t x;
    wdata  = $urandom;
    wr     = 1'b1;
    x.data = wdata;
    x.s    = (widx % PKT_LEN) == 0;
    x.e    = (widx % PKT_LEN) == PKT_LEN - 1;
    sb.push_back(x);
    widx++;
  endtask

  // Per-cycle output checks, run once per cycle at the falling edge.
  task automatic mon();
    exp_t x;
    @(negedge clk);
    if (!rst) begin
      chk("no_underflow", 64'(fifo_rd_en && !fifo_dn_ready), 64'd0);
      if (fmt_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_word actual=unexpected %h required=no word at %0t", fmt_data, $time);
        end else begin
          x = sb.pop_front();
          chk("sb_word", {fmt_data, fmt_start, fmt_end}, {x.data, x.s, x.e});
          last_data = x.data;
        end
        if (fmt_end) nends++;
      end else begin
        chk("idle_hold", {fmt_data, fmt_start, fmt_end}, {last_data, 2'b00});
      end
      if (v1) begin
        chk("len1_word", {d1, s1, e1}, {exp1, 2'b11});
        exp1 = exp1 + 1;
        words1++;
      end
    end
  endtask

  task automatic wait_req_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      wr    = 1'b0;
      grant = 1'b0;
      if (fmt_req) begin
        grant = 1'b1;
        mon();
        ok = 1'b1;
        return;
      end
      mon();
    end
    checks++;
    failures++;
    $display("FAIL req_wait actual=fmt_req low required=fmt_req high within 12 cycles");
  endtask

  task automatic fill4();
    for (int i = 0; i < 4; i++) begin
      cyc();
      push_word();
      mon();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    bit          ok;
    bit          rdy_pat [7];
    bit          rd_pat  [7];
    int unsigned written;
    bit          seen255;

    rst = 1'b1; wr = 1'b0; wdata = '0; grant = 1'b0; rdy_mask = 1'b1; g1_en = 1'b0;
    widx = 0; last_data = '0; nends = 0; exp1 = '0; words1 = 0;

    // Cycle table: threshold, grant-in-IDLE ignored, one packet, pkt_cnt bump.
    //            wr grant rdy | req rd  v   s   e   pkt
    tbl[0]  = mk(1, 0, 1,  0, 0, 0, 0, 0, 8'd0);
    tbl[1]  = mk(1, 0, 1,  0, 0, 0, 0, 0, 8'd0);
    tbl[2]  = mk(1, 0, 1,  0, 0, 0, 0, 0, 8'd0);
    tbl[3]  = mk(0, 1, 1,  0, 0, 0, 0, 0, 8'd0);
    tbl[4]  = mk(0, 0, 1,  0, 0, 0, 0, 0, 8'd0);
    tbl[5]  = mk(1, 0, 1,  0, 0, 0, 0, 0, 8'd0);
    tbl[6]  = mk(0, 0, 1,  0, 0, 0, 0, 0, 8'd0);
    tbl[7]  = mk(0, 0, 1,  1, 0, 0, 0, 0, 8'd0);
    tbl[8]  = mk(0, 0, 1,  1, 0, 0, 0, 0, 8'd0);
    tbl[9]  = mk(0, 1, 1,  1, 0, 0, 0, 0, 8'd0);
    tbl[10] = mk(0, 0, 1,  0, 1, 0, 0, 0, 8'd0);
    tbl[11] = mk(0, 0, 1,  0, 1, 0, 0, 0, 8'd0);
    tbl[12] = mk(0, 0, 1,  0, 1, 1, 1, 0, 8'd0);
    tbl[13] = mk(0, 0, 1,  0, 1, 1, 0, 0, 8'd0);
    tbl[14] = mk(0, 0, 1,  0, 0, 1, 0, 0, 8'd0);
    tbl[15] = mk(0, 0, 1,  0, 0, 1, 0, 1, 8'd0);
    tbl[16] = mk(0, 1, 1,  0, 0, 0, 0, 0, 8'd1);
    tbl[17] = mk(0, 0, 1,  0, 0, 0, 0, 0, 8'd1);

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      cyc();
      grant    = 1'($urandom);
      rdy_mask = 1'($urandom);
      wr       = 1'($urandom);
      wdata    = $urandom;
      g1_en    = 1'($urandom);
      @(negedge clk);
      chk("reset_outputs",
          {fifo_rd_en, fmt_req, fmt_valid, fmt_start, fmt_end, pkt_cnt, fmt_data},
          64'd0);
      chk("reset_outputs_len1", {rd1, req1, v1, s1, e1, pc1, d1}, 64'd0);
    end
    cyc();
    wr = 1'b0; grant = 1'b0; rdy_mask = 1'b1; g1_en = 1'b0; rst = 1'b0;
    mon();
    for (int i = 0; i < 3; i++) begin
      cyc();
      mon();
      chk("idle_after_reset", {fmt_req, fifo_rd_en, fmt_valid}, 64'd0);
    end

    // Table-driven threshold and single packet.
    for (int i = 0; i < 18; i++) begin
      cyc();
      wr       = 1'b0;
      grant    = tbl[i].grant;
      rdy_mask = tbl[i].rdy;
      if (tbl[i].wr) push_word();
      mon();
      chk($sformatf("tbl_row%0d", i),
          {fmt_req, fifo_rd_en, fmt_valid, fmt_start, fmt_end, pkt_cnt},
          {tbl[i].req, tbl[i].rd, tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].pkt});
    end
    cyc();
    grant = 1'b0;
    mon();

    // Stall: ready drops for two cycles after the second pop.
    rdy_pat = '{1, 1, 0, 0, 1, 1, 1};
    rd_pat  = '{1, 1, 0, 0, 1, 1, 0};
    fill4();
    wait_req_grant(ok);
    for (int k = 0; k < 7; k++) begin
      cyc();
      grant    = 1'b0;
      rdy_mask = rdy_pat[k];
      mon();
      chk($sformatf("stall_rd_en%0d", k), 64'(fifo_rd_en), 64'(rd_pat[k]));
    end
    rdy_mask = 1'b1;
    for (int i = 0; i < 10 && pkt_cnt != 8'd2; i++) begin
      cyc();
      mon();
    end
    chk("stall_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // Abort: reset during SEND after two words have been emitted.
    fill4();
    wait_req_grant(ok);
    for (int k = 0; k < 4; k++) begin
      cyc();
      grant = 1'b0;
      mon();
    end
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs", {fifo_rd_en, fmt_req, fmt_valid, fmt_start, fmt_end, pkt_cnt}, 64'd0);
    sb.delete();
    widx = 0; last_data = '0; exp1 = '0; words1 = 0;
    cyc();
    rst = 1'b0;
    mon();
    for (int i = 0; i < 3; i++) begin
      cyc();
      mon();
      chk("abort_not_counted", {fmt_valid, fmt_req, pkt_cnt}, 64'd0);
    end

    // Back-to-back packets with a level grant; pkt_cnt must wrap.
    grant = 1'b1; g1_en = 1'b1; nends = 0; written = 0; seen255 = 1'b0;
    for (int c = 0; c < 8000 && nends < 256; c++) begin
      cyc();
      wr = 1'b0;
      if (written < 1024 && count < 4'(MAX_CNT)) begin
        push_word();
        written++;
      end
      mon();
      if (pkt_cnt == 8'd255) seen255 = 1'b1;
    end
    wr = 1'b0; grant = 1'b0; g1_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      mon();
    end
    chk("wrap_ends", 64'(nends), 64'd256);
    chk("wrap_seen255", 64'(seen255), 64'd1);
    chk("wrap_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("len1_pkt_cnt", 64'(pc1), 64'(words1[7:0]));
    chk("len1_words_seen", 64'(words1 > 100), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
